// File: rtl/shift_operand_stage_pkg.sv
// Shared definitions for the shift operand stage.
// Holds the shift opcode encoding driven on sel, the funct3 values that
// identify shift instructions, the fixed LUI shift amount, and the layout
// of one buffered FIFO entry.
package shift_operand_stage_pkg;

  // Shift opcode encoding seen by the downstream shifter
  localparam logic [1:0] SHIFT_SRL = 2'b00;
  localparam logic [1:0] SHIFT_SLL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_LUI = 2'b11;

  // funct3 values of the shift instruction group
  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SR  = 3'b101;

  // LUI is realised as the immediate shifted by a fixed amount
  localparam int LUI_AMT = 12;

  // One buffered operation, exactly what the downstream port presents
  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] immrs1;
    logic [5:0]  immrs2;
    logic        zero_amt;
    logic [4:0]  rd;
  } shift_entry_t;

endpackage

// File: rtl/shift_operand_stage_fwd_mux.sv
// Operand forwarding mux for one source register.
// Ports:
//   addr        source register index being read
//   reg_data    value read from the register file
//   mem_en/rd/data  result currently in the MEM stage
//   wb_en/rd/data   result currently in the WB stage
//   data        resolved operand value
// MEM is the younger result and wins over WB; x0 always reads the register
// file value because it can never hold a written result.
module fwd_mux (
  input  logic [4:0]  addr,
  input  logic [31:0] reg_data,
  input  logic        mem_en,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] data
);

  logic hit_mem;
  logic hit_wb;

  assign hit_mem = mem_en && (mem_rd == addr) && (addr != 5'd0);
  assign hit_wb  = wb_en  && (wb_rd  == addr) && (addr != 5'd0);

  // Priority select: youngest matching producer first
  always_comb begin
    data = reg_data;
    if (hit_mem) begin
      data = mem_data;
    end else if (hit_wb) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/shift_operand_stage.sv
// Shift operand stage: decodes a shift/LUI request, resolves its source
// operands through MEM/WB forwarding, forms the value and amount to shift,
// and buffers the result in a 2-entry skid FIFO toward the shifter.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           upstream handshake (in_ready is registered)
//   funct3, funct7b5, is_imm, is_lui   instruction decode fields
//   rs1_addr/rs2_addr, rs1_data/rs2_data, imm, rd_in   operands and tag
//   fwd_mem_*, fwd_wb_*         forwarding sources
//   out_valid/out_ready         downstream handshake
//   sel, immrs1, immrs2, zero_amt, rd_out   head FIFO entry
//   flush                       drops everything buffered and in flight
//   illegal                     one-cycle pulse for a dropped non-shift request
module shift_operand_stage #(
  parameter int SHAMT_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        is_imm,
  input  logic        is_lui,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [4:0]  rd_in,
  input  logic        fwd_mem_en,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [31:0] fwd_mem_data,
  input  logic        fwd_wb_en,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  sel,
  output logic [31:0] immrs1,
  output logic [5:0]  immrs2,
  output logic        zero_amt,
  output logic [4:0]  rd_out,
  input  logic        flush,
  output logic        illegal
);

  import shift_operand_stage_pkg::*;

  logic [31:0]        rs1_res;
  logic [31:0]        rs2_res;
  logic               legal;
  logic [SHAMT_W-1:0] amount;
  shift_entry_t       new_entry;

  shift_entry_t       mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic [1:0]         count_next;
  logic               in_ready_q;
  logic               illegal_q;
  logic               accept;
  logic               push;
  logic               pop;

  // Only the low shift-amount bits of rs2 matter to a shift
  logic unused_rs2_hi;
  assign unused_rs2_hi = ^rs2_res[31:SHAMT_W];

  fwd_mux u_fwd_rs1 (
    .addr     (rs1_addr),
    .reg_data (rs1_data),
    .mem_en   (fwd_mem_en),
    .mem_rd   (fwd_mem_rd),
    .mem_data (fwd_mem_data),
    .wb_en    (fwd_wb_en),
    .wb_rd    (fwd_wb_rd),
    .wb_data  (fwd_wb_data),
    .data     (rs1_res)
  );

  fwd_mux u_fwd_rs2 (
    .addr     (rs2_addr),
    .reg_data (rs2_data),
    .mem_en   (fwd_mem_en),
    .mem_rd   (fwd_mem_rd),
    .mem_data (fwd_mem_data),
    .wb_en    (fwd_wb_en),
    .wb_rd    (fwd_wb_rd),
    .wb_data  (fwd_wb_data),
    .data     (rs2_res)
  );

  // Decode the request into an entry. LUI overrides funct3 and becomes
  // "imm shifted by a fixed 12"; anything that is neither LUI nor a shift
  // funct3 is flagged illegal and never reaches the FIFO.
  always_comb begin
    legal              = 1'b1;
    amount             = is_imm ? imm[SHAMT_W-1:0] : rs2_res[SHAMT_W-1:0];
    new_entry.sel      = SHIFT_SRL;
    new_entry.immrs1   = rs1_res;
    if (is_lui) begin
      new_entry.sel    = SHIFT_LUI;
      new_entry.immrs1 = imm;
      amount           = SHAMT_W'(LUI_AMT);
    end else if (funct3 == FUNCT3_SLL) begin
      new_entry.sel    = SHIFT_SLL;
    end else if (funct3 == FUNCT3_SR) begin
      new_entry.sel    = funct7b5 ? SHIFT_SRA : SHIFT_SRL;
    end else begin
      legal            = 1'b0;
    end
    new_entry.immrs2   = 6'(amount);
    // The shifter cannot shift by zero, so a zero amount is flagged for bypass
    new_entry.zero_amt = (new_entry.immrs2 == 6'd0);
    new_entry.rd       = rd_in;
  end

  assign accept = in_valid && in_ready_q;
  assign push   = accept && legal && !flush;
  assign pop    = out_valid && out_ready && !flush;

  // Occupancy update; flush wins over any simultaneous push or pop
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = 2'd0;
    end else if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
  end

  // FIFO storage, 1-bit pointers that wrap naturally, registered in_ready
  // derived from next occupancy so it is valid the cycle after any change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      in_ready_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      illegal_q  <= accept && !legal;
      count      <= count_next;
      in_ready_q <= (count_next != 2'd2);
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= new_entry;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign illegal   = illegal_q;
  assign out_valid = (count != 2'd0);
  assign sel       = mem[rd_ptr].sel;
  assign immrs1    = mem[rd_ptr].immrs1;
  assign immrs2    = mem[rd_ptr].immrs2;
  assign zero_amt  = mem[rd_ptr].zero_amt;
  assign rd_out    = mem[rd_ptr].rd;

endmodule
